// File: rtl/ctrl_varredura_matriz_pkg.sv
// Shared types and constants for the 7x5 LED matrix row-scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pkg_matriz;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BLANK   = 2'd1,
    ATIVO   = 2'd2,
    DESLOCA = 2'd3
  } estado_t;

  localparam int NUM_LINHAS  = 5;
  localparam int LARG_LINHA  = 3;
  localparam int LARG_COLUNA = 7;

  // Bits needed to hold the values 0..n-1, never less than one bit.
  function automatic int f_larg(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ctrl_varredura_matriz_contador_slot.sv
// Loadable down-counter timing the blank and active phases of a row slot.
// Latency: load takes effect next cycle; o_tc is combinational on the count.
// Backpressure: none; holds at zero until reloaded, counts only while i_en.
module contador_slot
  import pkg_matriz::*;
#(
  parameter int LARGURA = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_carga,
  input  logic [LARGURA-1:0] i_valor,
  input  logic               i_en,
  output logic               o_tc
);

  logic [LARGURA-1:0] r_cnt;

  // Load has priority; otherwise count down to zero and stick there.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_carga) begin
      r_cnt <= i_valor;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - LARGURA'(1);
    end
  end

  // Terminal count: the last cycle of the loaded interval.
  assign o_tc = i_en && (r_cnt == '0);

endmodule

// File: rtl/ctrl_varredura_matriz.sv
// Row-scan controller: blanks, drives each row in turn and requests scroll shifts.
// Latency: all outputs registered, they reflect the state entered at the last edge.
// Backpressure: desloca_req holds the scan until desloca_ack; no timeout.
module ctrl_varredura_matriz
  import pkg_matriz::*;
#(
  parameter int CLK_DIV          = 50000,
  parameter int BLANK_CYC        = 8,
  parameter int NUM_LINHAS       = pkg_matriz::NUM_LINHAS,
  parameter int FRAMES_POR_PASSO = 20,
  parameter int MSG_LEN          = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_en,
  input  logic                          i_modo,
  input  logic                          i_desloca_ack,
  output logic [LARG_LINHA-1:0]         o_sel,
  output logic [NUM_LINHAS-1:0]         o_linha_onehot,
  output logic                          o_linha_en,
  output logic                          o_desloca_req,
  output logic [f_larg(MSG_LEN)-1:0]    o_offset,
  output logic                          o_fim_quadro,
  output logic                          o_busy
);

  localparam int LARG_OFF    = f_larg(MSG_LEN);
  localparam int LARG_CNT    = f_larg(CLK_DIV);
  localparam int LARG_QUADRO = f_larg(FRAMES_POR_PASSO + 1);

  // Counter reloads are interval length minus one: it counts down to zero inclusive.
  localparam logic [LARG_CNT-1:0]    CARGA_BLANK   = LARG_CNT'(BLANK_CYC - 1);
  localparam logic [LARG_CNT-1:0]    CARGA_ATIVO   = LARG_CNT'(CLK_DIV - BLANK_CYC - 1);
  localparam logic [LARG_LINHA-1:0]  ULTIMA_LINHA  = LARG_LINHA'(NUM_LINHAS - 1);
  localparam logic [LARG_QUADRO-1:0] QUADROS_PASSO = LARG_QUADRO'(FRAMES_POR_PASSO);
  localparam logic [LARG_OFF-1:0]    ULTIMO_OFF    = LARG_OFF'(MSG_LEN - 1);

  estado_t                r_estado;
  logic [LARG_LINHA-1:0]  r_linha;
  logic [LARG_QUADRO-1:0] r_quadro;
  logic [LARG_OFF-1:0]    r_offset;

  logic [LARG_LINHA-1:0]  r_sel;
  logic [NUM_LINHAS-1:0]  r_onehot;
  logic                   r_linha_en;
  logic                   r_req;
  logic                   r_fim;
  logic                   r_busy;

  estado_t                w_prox_estado;
  logic [LARG_LINHA-1:0]  w_prox_linha;
  logic [LARG_QUADRO-1:0] w_prox_quadro;
  logic [LARG_QUADRO-1:0] w_quadro_inc;
  logic [LARG_OFF-1:0]    w_prox_offset;
  logic                   w_prox_fim;
  logic                   w_carga;
  logic [LARG_CNT-1:0]    w_valor;
  logic                   w_cnt_en;
  logic                   w_tc;

  assign w_cnt_en     = (r_estado == BLANK) || (r_estado == ATIVO);
  assign w_quadro_inc = r_quadro + LARG_QUADRO'(1);

  contador_slot #(
    .LARGURA (LARG_CNT)
  ) u_contador_slot (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_carga (w_carga),
    .i_valor (w_valor),
    .i_en    (w_cnt_en),
    .o_tc    (w_tc)
  );

  // State, row, frame and offset registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_estado <= IDLE;
      r_linha  <= '0;
      r_quadro <= '0;
      r_offset <= '0;
    end else begin
      r_estado <= w_prox_estado;
      r_linha  <= w_prox_linha;
      r_quadro <= w_prox_quadro;
      r_offset <= w_prox_offset;
    end
  end

  // Next-state logic; dropping en wins over a slot end in BLANK/ATIVO.
  always_comb begin
    w_prox_estado = r_estado;
    w_prox_linha  = r_linha;
    w_prox_quadro = r_quadro;
    w_prox_offset = r_offset;
    w_prox_fim    = 1'b0;
    w_carga       = 1'b0;
    w_valor       = CARGA_BLANK;
    unique case (r_estado)
      IDLE: begin
        if (i_en) begin
          w_prox_estado = BLANK;
          w_prox_linha  = '0;
          w_carga       = 1'b1;
        end
      end
      BLANK, ATIVO: begin
        if (!i_en) begin
          w_prox_estado = IDLE;
          w_prox_linha  = '0;
          w_prox_quadro = '0;
          w_carga       = 1'b1;
          w_valor       = '0;
        end else if (w_tc && (r_estado == BLANK)) begin
          w_prox_estado = ATIVO;
          w_carga       = 1'b1;
          w_valor       = CARGA_ATIVO;
        end else if (w_tc) begin
          w_carga = 1'b1;
          if (r_linha < ULTIMA_LINHA) begin
            w_prox_linha  = r_linha + LARG_LINHA'(1);
            w_prox_estado = BLANK;
          end else begin
            w_prox_linha  = '0;
            w_prox_fim    = 1'b1;
            w_prox_estado = BLANK;
            if (!i_modo) begin
              w_prox_quadro = '0;
            end else if (w_quadro_inc == QUADROS_PASSO) begin
              w_prox_quadro = '0;
              w_prox_estado = DESLOCA;
            end else begin
              w_prox_quadro = w_quadro_inc;
            end
          end
        end
      end
      DESLOCA: begin
        if (i_desloca_ack) begin
          w_prox_offset = (r_offset == ULTIMO_OFF) ? '0 : r_offset + LARG_OFF'(1);
          w_prox_linha  = '0;
          w_carga       = 1'b1;
          if (i_en) begin
            w_prox_estado = BLANK;
          end else begin
            w_prox_estado = IDLE;
            w_prox_quadro = '0;
            w_valor       = '0;
          end
        end
      end
      default: w_prox_estado = IDLE;
    endcase
  end

  // Output registers, driven from the state being entered so they align with it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sel      <= '0;
      r_onehot   <= '0;
      r_linha_en <= 1'b0;
      r_req      <= 1'b0;
      r_fim      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_sel      <= ((w_prox_estado == BLANK) || (w_prox_estado == ATIVO)) ? w_prox_linha : '0;
      r_onehot   <= (w_prox_estado == ATIVO) ? (NUM_LINHAS'(1) << w_prox_linha) : '0;
      r_linha_en <= (w_prox_estado == ATIVO);
      r_req      <= (w_prox_estado == DESLOCA);
      r_fim      <= w_prox_fim;
      r_busy     <= (w_prox_estado != IDLE);
    end
  end

  assign o_sel          = r_sel;
  assign o_linha_onehot = r_onehot;
  assign o_linha_en     = r_linha_en;
  assign o_desloca_req  = r_req;
  assign o_offset       = r_offset;
  assign o_fim_quadro   = r_fim;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_ctrl_varredura_matriz.sv
// Directed bench for the row-scan controller with a 10-cycle slot and 2-cycle blank.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: desloca_ack driven directly by the stimulus steps.
module tb_ctrl_varredura_matriz;

  logic       clk;
  logic       rst;
  logic       en;
  logic       modo;
  logic       ack;
  logic [2:0] sel;
  logic [4:0] onehot;
  logic       linha_en;
  logic       req;
  logic [1:0] offset;
  logic       fim;
  logic       busy;

  int vetores = 0;
  int erros   = 0;

  ctrl_varredura_matriz #(
    .CLK_DIV          (10),
    .BLANK_CYC        (2),
    .NUM_LINHAS       (5),
    .FRAMES_POR_PASSO (2),
    .MSG_LEN          (4)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_en           (en),
    .i_modo         (modo),
    .i_desloca_ack  (ack),
    .o_sel          (sel),
    .o_linha_onehot (onehot),
    .o_linha_en     (linha_en),
    .o_desloca_req  (req),
    .o_offset       (offset),
    .o_fim_quadro   (fim),
    .o_busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vetores++;
    assert (obs === exp) else begin
      erros++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    en   = 1'b0;
    modo = 1'b0;
    ack  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    modo = 1'b0;
    ack  = 1'b0;

    // Reset state, and IDLE holds while en=0.
    do_reset();
    chk("rst_sel", 8'(sel), 8'd0);
    chk("rst_onehot", 8'(onehot), 8'd0);
    chk("rst_linha_en", 8'(linha_en), 8'd0);
    chk("rst_req", 8'(req), 8'd0);
    chk("rst_offset", 8'(offset), 8'd0);
    chk("rst_fim", 8'(fim), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    tick();
    chk("idle_busy", 8'(busy), 8'd0);

    // Static scan over two frames; a stray ack must be ignored.
    en  = 1'b1;
    ack = 1'b1;
    for (int k = 0; k < 100; k++) begin
      int  e_sel;
      logic e_en;
      tick();
      e_sel = (k % 50) / 10;
      e_en  = ((k % 10) >= 2);
      chk("scan_sel", 8'(sel), 8'(e_sel));
      chk("scan_linha_en", 8'(linha_en), 8'(e_en));
      chk("scan_onehot", 8'(onehot), e_en ? 8'(1 << e_sel) : 8'd0);
      chk("scan_fim", 8'(fim), 8'((k > 0) && (k % 50 == 0)));
      chk("scan_req", 8'(req), 8'd0);
      chk("scan_busy", 8'(busy), 8'd1);
    end
    chk("scan_offset", 8'(offset), 8'd0);

    // Scroll with ack tied high: one-cycle req every second frame, offset wraps.
    do_reset();
    en   = 1'b1;
    modo = 1'b1;
    ack  = 1'b1;
    tick();
    for (int s = 1; s <= 4; s++) begin
      repeat (99) tick();
      chk("scr_req_before", 8'(req), 8'd0);
      tick();
      chk("scr_req", 8'(req), 8'd1);
      chk("scr_fim", 8'(fim), 8'd1);
      chk("scr_linha_en", 8'(linha_en), 8'd0);
      chk("scr_offset_old", 8'(offset), 8'(s - 1));
      tick();
      chk("scr_req_drop", 8'(req), 8'd0);
      chk("scr_offset_new", 8'(offset), 8'(s % 4));
      chk("scr_sel", 8'(sel), 8'd0);
      chk("scr_blank", 8'(linha_en), 8'd0);
    end

    // Scroll with ack arriving 5 cycles after req.
    do_reset();
    en   = 1'b1;
    modo = 1'b1;
    ack  = 1'b0;
    repeat (101) tick();
    chk("dly_req_rise", 8'(req), 8'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("dly_req_hold", 8'(req), 8'd1);
      chk("dly_linha_en", 8'(linha_en), 8'd0);
      chk("dly_onehot", 8'(onehot), 8'd0);
    end
    chk("dly_offset_hold", 8'(offset), 8'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("dly_req_drop", 8'(req), 8'd0);
    chk("dly_offset", 8'(offset), 8'd1);
    chk("dly_sel", 8'(sel), 8'd0);
    chk("dly_blank0", 8'(linha_en), 8'd0);
    tick();
    chk("dly_blank1", 8'(linha_en), 8'd0);
    tick();
    chk("dly_ativo", 8'(linha_en), 8'd1);
    chk("dly_ativo_oh", 8'(onehot), 8'h01);

    // en dropped mid-ATIVO on row 3, then re-enabled.
    repeat (33) tick();
    chk("drop_sel3", 8'(sel), 8'd3);
    chk("drop_oh3", 8'(onehot), 8'h08);
    en = 1'b0;
    tick();
    chk("drop_sel", 8'(sel), 8'd0);
    chk("drop_onehot", 8'(onehot), 8'd0);
    chk("drop_linha_en", 8'(linha_en), 8'd0);
    chk("drop_busy", 8'(busy), 8'd0);
    chk("drop_offset", 8'(offset), 8'd1);
    tick();
    chk("drop_idle", 8'(busy), 8'd0);
    en = 1'b1;
    tick();
    chk("reen_busy", 8'(busy), 8'd1);
    chk("reen_sel", 8'(sel), 8'd0);
    chk("reen_blank", 8'(linha_en), 8'd0);
    tick();
    tick();
    chk("reen_ativo", 8'(linha_en), 8'd1);
    chk("reen_oh", 8'(onehot), 8'h01);
    chk("reen_offset", 8'(offset), 8'd1);

    // en dropped during DESLOCA: handshake finishes, then IDLE.
    do_reset();
    en   = 1'b1;
    modo = 1'b1;
    ack  = 1'b0;
    repeat (101) tick();
    chk("dsl_req", 8'(req), 8'd1);
    en = 1'b0;
    tick();
    chk("dsl_req_hold1", 8'(req), 8'd1);
    chk("dsl_busy", 8'(busy), 8'd1);
    tick();
    chk("dsl_req_hold2", 8'(req), 8'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("dsl_req_drop", 8'(req), 8'd0);
    chk("dsl_offset", 8'(offset), 8'd1);
    chk("dsl_idle", 8'(busy), 8'd0);
    chk("dsl_linha_en", 8'(linha_en), 8'd0);
    tick();
    chk("dsl_stay_idle", 8'(busy), 8'd0);
    chk("dsl_offset_keep", 8'(offset), 8'd1);

    // Asynchronous reset mid-ATIVO clears outputs without a clock edge.
    en = 1'b1;
    repeat (3) tick();
    chk("ar_ativo", 8'(linha_en), 8'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_linha_en", 8'(linha_en), 8'd0);
    chk("ar_onehot", 8'(onehot), 8'd0);
    chk("ar_sel", 8'(sel), 8'd0);
    chk("ar_busy", 8'(busy), 8'd0);
    chk("ar_offset", 8'(offset), 8'd0);
    chk("ar_req", 8'(req), 8'd0);
    rst = 1'b0;
    en  = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
    $finish;
  end

endmodule

// File: doc/ctrl_varredura_matriz.md
Name: ctrl_varredura_matriz

Overview:
Row-scan controller for the 7x5 LED matrix panel. It time-multiplexes the five row registers through the row demultiplexer, drives the 3-bit select and row enables, and inserts a blanking gap between rows to suppress ghosting. In scroll mode it periodically requests a one-position shift of the message register bank through a req/ack handshake, and it tracks the message offset.

Parameters:
CLK_DIV, 50000, clock cycles per row slot (blank + active); must be > BLANK_CYC
BLANK_CYC, 8, cycles of blanking at the start of each row slot; must be >= 1
NUM_LINHAS, 5, rows scanned per frame
FRAMES_POR_PASSO, 20, frames between scroll steps
MSG_LEN, 16, message length in columns; offset wraps modulo MSG_LEN

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  scan enable
modo  in  1  0 = static display, 1 = scroll
desloca_ack  in  1  register bank has completed the shift
sel  out  3  row index to the demux (0..NUM_LINHAS-1)
linha_onehot  out  NUM_LINHAS  one-hot row drive; all zero when blanked
linha_en  out  1  high only during the active part of a row slot
desloca_req  out  1  shift request to the register bank
offset  out  clog2(MSG_LEN)  current message start column
fim_quadro  out  1  one-cycle pulse at the end of each frame
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE; sel=0, linha_onehot=0, linha_en=0, desloca_req=0, offset=0, fim_quadro=0, busy=0; row, slot and frame counters all 0.
- All outputs are registered.
- FSM states: IDLE, BLANK, ATIVO, DESLOCA.
- IDLE
  - All drives are off.
  - If en=1: next state BLANK with row=0 and slot counter=0.
- BLANK
  - sel=row, linha_en=0, linha_onehot=0.
  - Holds for exactly BLANK_CYC cycles, then goes to ATIVO.
- ATIVO
  - linha_en=1, linha_onehot=1<<row.
  - Holds for CLK_DIV-BLANK_CYC cycles.
  - At the end of the slot:
    - If row<NUM_LINHAS-1: row+1, go to BLANK.
    - Otherwise: row=0, fim_quadro pulses for 1 cycle, and the frame counter increments.
      - If modo=1 and the frame counter reaches FRAMES_POR_PASSO: frame counter=0, go to DESLOCA.
      - Otherwise: go to BLANK.
- Row slot period is exactly CLK_DIV cycles. Frame period is NUM_LINHAS*CLK_DIV cycles, plus handshake time when a shift occurs.
- DESLOCA
  - linha_en=0, desloca_req=1.
  - desloca_req stays high until desloca_ack is sampled high.
  - The cycle after ack: desloca_req=0, offset=(offset+1) mod MSG_LEN, state BLANK with row 0.
  - Ack sampled the same cycle req rises is accepted (minimum 1-cycle handshake).
  - No timeout.
- desloca_ack while desloca_req=0 is ignored.
- en=0 in BLANK or ATIVO: next cycle IDLE; outputs off; row, slot and frame counters cleared; offset retained.
- en=0 in DESLOCA: the handshake completes first (offset updated), then the controller goes to IDLE.
- A modo change is sampled only at frame end. Switching to 0 clears the frame counter.
- The frame counter does not advance when modo=0.
- Asynchronous rst mid-operation, including mid-handshake: immediate return to reset values; desloca_req drops asynchronously.

Decomposition:
- Shared package pkg_matriz holds:
  - state enum (IDLE, BLANK, ATIVO, DESLOCA)
  - NUM_LINHAS, row width 3, column width 7
  - a clog2-based width function for offset and counters
- One sub-module, contador_slot: a parameterised down-counter with load, enable and terminal-count pulse. It times both the BLANK and ATIVO phases.

Test Plan:
(All scenarios use CLK_DIV=10, BLANK_CYC=2, FRAMES_POR_PASSO=2, MSG_LEN=4.)
- Reset then en=1, modo=0 -> sel steps 0,1,2,3,4,0 every 10 cycles; linha_en low for cycles 0-1 and high for cycles 2-9 of each slot; linha_onehot=00001,00010,...; fim_quadro pulses every 50 cycles; desloca_req never rises.
- modo=1, ack tied high -> desloca_req pulses for 1 cycle after every second frame; offset goes 0,1,2,3,0 (wrap), checked over 8 frames.
- modo=1, ack delayed 5 cycles -> desloca_req held exactly until ack; linha_en=0 throughout; offset increments once; the scan resumes at row 0 with a BLANK phase.
- en dropped mid-ATIVO on row 3 -> next cycle IDLE, all drives 0, busy=0; offset preserved; re-enable restarts at row 0.
- en dropped during DESLOCA, ack after 3 cycles -> offset increments, then IDLE; rst asserted mid-ATIVO -> all outputs 0 immediately, without waiting for a clock edge.
